// File: rtl/jtcop_mcu_bridge_if.sv
// Main-CPU side bus of the 68000 <-> i8751 bridge.
//   main_wr/main_din/main_dsn : one-cycle write strobe, data, active-low byte strobes {UDSn,LDSn}
//   main_rd                   : one-cycle read strobe, acknowledges the response word
//   mcu_dout/dout_rdy         : response word from the MCU and its "new data" flag
//   main_busy                 : command FIFO full
// master = main CPU decode, slave = bridge.
interface jtcop_mcu_bridge_if;
  logic        main_wr;
  logic [15:0] main_din;
  logic [1:0]  main_dsn;
  logic        main_rd;
  logic [15:0] mcu_dout;
  logic        dout_rdy;
  logic        main_busy;

  modport master (output main_wr, main_din, main_dsn, main_rd,
                  input  mcu_dout, dout_rdy, main_busy);
  modport slave  (input  main_wr, main_din, main_dsn, main_rd,
                  output mcu_dout, dout_rdy, main_busy);
endinterface

// File: rtl/jtcop_mcu_bridge.sv
// Buffered handshake bridge between the Dec0/Cop 68000 and the i8751 protection MCU.
//   - DEPTH-word command FIFO (main -> MCU), drained byte-wise through P0 on
//     rising edges of P2[4] (high byte, peek) and P2[5] (low byte, pop).
//   - Response register (MCU -> main) loaded on rising P2[6] (low) / P2[7] (high, flags ready).
//   - INT1 to the MCU while the FIFO holds data and P2[3] enables it.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   bus (slave)        : main CPU side, see jtcop_mcu_bridge_if
//   p0_o, p2_o         : MCU port outputs
//   p0_i, int1n        : MCU port 0 input, INT1 (active low)
//   ovf_cnt            : dropped-write counter
// Optional feature macro: JTCOP_MCU_OVF_EN enables the saturating ovf_cnt counter;
// without it ovf_cnt is tied to zero.
// DEPTH must be a power of two (>=2) and AW = log2(DEPTH).
module jtcop_mcu_bridge #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  jtcop_mcu_bridge_if.slave       bus,
  input  logic [7:0]              p0_o,
  input  logic [7:0]              p2_o,
  output logic [7:0]              p0_i,
  output logic                    int1n,
  output logic [7:0]              ovf_cnt
);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, w_cnt_nxt;
  logic [7:0]    r_p2l, r_p0_i;
  logic [15:0]   r_dout;
  logic          r_dout_rdy, r_int1n, r_busy;

  logic [7:0]    w_rise;
  logic          w_full, w_empty, w_pop, w_push, w_drop;
  logic [15:0]   w_wdata, w_head;

  assign w_rise  = p2_o & ~r_p2l;
  assign w_full  = r_count == (AW+1)'(DEPTH);
  assign w_empty = r_count == '0;
  assign w_pop   = w_rise[5] & ~w_empty;
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign w_push  = bus.main_wr & (~w_full | w_pop);
  assign w_drop  = bus.main_wr & ~w_push;
  assign w_wdata = {bus.main_dsn[1] ? 8'h00 : bus.main_din[15:8],
                    bus.main_dsn[0] ? 8'h00 : bus.main_din[7:0]};
  assign w_head  = r_mem[r_rd_ptr];

  // P2[0..3] edges are not used; P2[3] is a level enable.
  logic w_unused;
  assign w_unused = &{1'b0, w_rise[3:0]};

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop)      w_cnt_nxt = r_count + (AW+1)'(1);
    else if (!w_push && w_pop) w_cnt_nxt = r_count - (AW+1)'(1);
  end

  // Storage needs no reset: pointers/count define what is valid.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= w_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_p2l    <= 8'hFF;  // no false edge on the first cycle out of reset
      r_p0_i   <= 8'hFF;
      r_int1n  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_p2l   <= p2_o;
      r_count <= w_cnt_nxt;
      r_int1n <= ~((w_cnt_nxt != '0) & p2_o[3]);
      r_busy  <= w_cnt_nxt == (AW+1)'(DEPTH);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      // Low-byte strobe wins P0 when both edges arrive together.
      if (w_rise[5])      r_p0_i <= w_empty ? 8'hFF : w_head[7:0];
      else if (w_rise[4]) r_p0_i <= w_empty ? 8'hFF : w_head[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout     <= 16'h0000;
      r_dout_rdy <= 1'b0;
    end else begin
      if (w_rise[6]) r_dout[7:0]  <= p0_o;
      if (w_rise[7]) r_dout[15:8] <= p0_o;
      if (w_rise[7])        r_dout_rdy <= 1'b1;  // set beats a same-cycle read
      else if (bus.main_rd) r_dout_rdy <= 1'b0;
    end
  end

`ifdef JTCOP_MCU_OVF_EN
  logic [7:0] r_ovf;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_ovf <= 8'h00;
    else if (w_drop && r_ovf != 8'hFF)     r_ovf <= r_ovf + 8'd1;
    else if (bus.main_rd && !r_dout_rdy)   r_ovf <= 8'h00;
  end
  assign ovf_cnt = r_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_drop;
  assign ovf_cnt      = 8'h00;
`endif

  assign p0_i          = r_p0_i;
  assign int1n         = r_int1n;
  assign bus.mcu_dout  = r_dout;
  assign bus.dout_rdy  = r_dout_rdy;
  assign bus.main_busy = r_busy;

endmodule

// File: tb/tb_jtcop_mcu_bridge.sv
module tb_jtcop_mcu_bridge;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p0_o, p2_o, p0_i, ovf_cnt;
  logic       int1n;
  int         errs = 0, checks = 0;

`ifdef JTCOP_MCU_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  jtcop_mcu_bridge_if bus();

  jtcop_mcu_bridge #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .p0_o(p0_o), .p2_o(p2_o), .p0_i(p0_i), .int1n(int1n), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] din;
    logic [1:0]  dsn;
    logic        rd;
    logic [7:0]  p0o, p2o;
    logic [7:0]  p0i;
    logic        int1n, busy;
    logic [15:0] dout;
    logic        rdy;
    logic [7:0]  ovf;   // expected when the counter is built in
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic wr, logic [15:0] din, logic [1:0] dsn, logic rd,
                             logic [7:0] p0o, logic [7:0] p2o, logic [7:0] p0i,
                             logic i1n, logic busy, logic [15:0] dout, logic rdy,
                             logic [7:0] ovf);
    vec_t t;
    t.wr = wr; t.din = din; t.dsn = dsn; t.rd = rd; t.p0o = p0o; t.p2o = p2o;
    t.p0i = p0i; t.int1n = i1n; t.busy = busy; t.dout = dout; t.rdy = rdy;
    t.ovf = OVF ? ovf : 8'h00;
    return t;
  endfunction

  task automatic drive(logic wr, logic [15:0] din, logic [1:0] dsn, logic rd,
                       logic [7:0] p0, logic [7:0] p2);
    bus.main_wr = wr; bus.main_din = din; bus.main_dsn = dsn; bus.main_rd = rd;
    p0_o = p0; p2_o = p2;
  endtask

  // Apply inputs for exactly one active edge, then sample 1 time unit later.
  task automatic step(logic wr, logic [15:0] din, logic [1:0] dsn, logic rd,
                      logic [7:0] p0, logic [7:0] p2);
    drive(wr, din, dsn, rd, p0, p2);
    @(posedge clk); #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Test 1: push A55A, peek high byte, pop low byte
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'hFF,1,0,16'h0000,0,8'h00));
    tbl.push_back(v(1,16'hA55A,2'b00,0,8'h00,8'h08, 8'hFF,0,0,16'h0000,0,8'h00));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h18, 8'hA5,0,0,16'h0000,0,8'h00));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'hA5,0,0,16'h0000,0,8'h00));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h28, 8'h5A,1,0,16'h0000,0,8'h00));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'h5A,1,0,16'h0000,0,8'h00));
    // Test 2: LDSn high masks the low byte
    tbl.push_back(v(1,16'h1234,2'b01,0,8'h00,8'h08, 8'h5A,0,0,16'h0000,0,8'h00));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h18, 8'h12,0,0,16'h0000,0,8'h00));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'h12,0,0,16'h0000,0,8'h00));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h28, 8'h00,1,0,16'h0000,0,8'h00));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'h00,1,0,16'h0000,0,8'h00));
    // Test 3: five writes into a 4-deep FIFO, fifth dropped
    tbl.push_back(v(1,16'h0001,2'b00,0,8'h00,8'h08, 8'h00,0,0,16'h0000,0,8'h00));
    tbl.push_back(v(1,16'h0002,2'b00,0,8'h00,8'h08, 8'h00,0,0,16'h0000,0,8'h00));
    tbl.push_back(v(1,16'h0003,2'b00,0,8'h00,8'h08, 8'h00,0,0,16'h0000,0,8'h00));
    tbl.push_back(v(1,16'h0004,2'b00,0,8'h00,8'h08, 8'h00,0,1,16'h0000,0,8'h00));
    tbl.push_back(v(1,16'h0005,2'b00,0,8'h00,8'h08, 8'h00,0,1,16'h0000,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h28, 8'h01,0,0,16'h0000,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'h01,0,0,16'h0000,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h28, 8'h02,0,0,16'h0000,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'h02,0,0,16'h0000,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h28, 8'h03,0,0,16'h0000,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'h03,0,0,16'h0000,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h28, 8'h04,1,0,16'h0000,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'h04,1,0,16'h0000,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h28, 8'hFF,1,0,16'h0000,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'hFF,1,0,16'h0000,0,8'h01));
    // Test 5: response handshake
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h34,8'h48, 8'hFF,1,0,16'h0034,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h12,8'h08, 8'hFF,1,0,16'h0034,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h12,8'h88, 8'hFF,1,0,16'h1234,1,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'hFF,1,0,16'h1234,1,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,1,8'h00,8'h08, 8'hFF,1,0,16'h1234,0,8'h01));
    tbl.push_back(v(0,16'h0000,2'b00,1,8'h00,8'h08, 8'hFF,1,0,16'h1234,0,8'h00));
    tbl.push_back(v(0,16'h0000,2'b00,1,8'h56,8'h88, 8'hFF,1,0,16'h5634,1,8'h00));
    tbl.push_back(v(0,16'h0000,2'b00,0,8'h00,8'h08, 8'hFF,1,0,16'h5634,1,8'h00));

    // Reset state
    rst = 1'b0;
    drive(0, 16'h0, 2'b00, 0, 8'h00, 8'h08);
    #12;
    chk("rst_p0_i",  {24'h0, p0_i}, 32'h0000_00FF);
    chk("rst_int1n", {31'h0, int1n}, 32'h1);
    chk("rst_busy",  {31'h0, bus.main_busy}, 32'h0);
    chk("rst_dout",  {15'h0, bus.mcu_dout, bus.dout_rdy}, 32'h0);
    chk("rst_ovf",   {24'h0, ovf_cnt}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      step(t.wr, t.din, t.dsn, t.rd, t.p0o, t.p2o);
      checks++;
      if ({p0_i, int1n, bus.main_busy, bus.mcu_dout, bus.dout_rdy, ovf_cnt} !==
          {t.p0i, t.int1n, t.busy, t.dout, t.rdy, t.ovf}) begin
        errs++;
        $display("FAIL vec%0d: got p0i=%h i1n=%b busy=%b dout=%h rdy=%b ovf=%h expected p0i=%h i1n=%b busy=%b dout=%h rdy=%b ovf=%h",
                 i, p0_i, int1n, bus.main_busy, bus.mcu_dout, bus.dout_rdy, ovf_cnt,
                 t.p0i, t.int1n, t.busy, t.dout, t.rdy, t.ovf);
      end
    end

    // Test 4: full FIFO, push and pop in the same cycle
    step(1, 16'h1111, 2'b00, 0, 8'h00, 8'h08);
    step(1, 16'h2222, 2'b00, 0, 8'h00, 8'h08);
    step(1, 16'h3333, 2'b00, 0, 8'h00, 8'h08);
    step(1, 16'h4444, 2'b00, 0, 8'h00, 8'h08);
    chk("full_busy", {31'h0, bus.main_busy}, 32'h1);
    step(1, 16'h5555, 2'b00, 0, 8'h00, 8'h28);
    chk("pp_p0_i", {24'h0, p0_i}, 32'h11);
    chk("pp_busy", {31'h0, bus.main_busy}, 32'h1);
    chk("pp_ovf",  {24'h0, ovf_cnt}, 32'h0);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h08);
    chk("pp_busy_hold", {31'h0, bus.main_busy}, 32'h1);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h28); chk("pp_drain2", {24'h0, p0_i}, 32'h22);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h08);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h28); chk("pp_drain3", {24'h0, p0_i}, 32'h33);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h08);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h28); chk("pp_drain4", {24'h0, p0_i}, 32'h44);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h08);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h28); chk("pp_drain5", {24'h0, p0_i}, 32'h55);
    chk("pp_int1n", {31'h0, int1n}, 32'h1);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h08);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h28); chk("pp_empty", {24'h0, p0_i}, 32'hFF);

    // Test 6: interrupt gating, then asynchronous reset mid-transfer
    step(1, 16'h7788, 2'b00, 0, 8'h00, 8'h08);
    chk("gate_push", {31'h0, int1n}, 32'h0);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h00);
    chk("gate_off1", {31'h0, int1n}, 32'h1);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h00);
    chk("gate_off2", {31'h0, int1n}, 32'h1);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h08);
    chk("gate_on", {31'h0, int1n}, 32'h0);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h18);
    chk("gate_peek", {24'h0, p0_i}, 32'h77);
    drive(0, 16'h0, 2'b00, 0, 8'h00, 8'h08);
    #2 rst = 1'b0;
    #1;
    chk("arst_int1n", {31'h0, int1n}, 32'h1);
    chk("arst_p0_i",  {24'h0, p0_i}, 32'hFF);
    chk("arst_dout",  {15'h0, bus.mcu_dout, bus.dout_rdy}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h08);
    chk("arst_cnt0", {31'h0, int1n}, 32'h1);
    step(0, 16'h0, 2'b00, 0, 8'h00, 8'h28);
    chk("arst_empty_pop", {24'h0, p0_i}, 32'hFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
